// File: rtl/rambit_pkg.sv
// Shared state encoding and elaboration helpers for the bit-masked RAM controller.
package rambit_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Ceiling log2, used to size the round-robin pointer.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rambit_rrarb.sv
// NR-way round-robin arbiter: one-hot grant searched upward from the pointer,
// pointer moves past the winner whenever the grant is taken.
module rambit_rrarb
    import rambit_pkg::*;
#(
    parameter int unsigned NR = 2
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [NR-1:0] req,
    input  logic          advance,
    output logic [NR-1:0] grant
);

    localparam int unsigned PW = clog2(NR);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = PW'((32'(ptr_q) + k) % NR);
            if (!found && req[idx]) begin
                found      = 1'b1;
                win        = idx;
                grant[idx] = 1'b1;
            end
        end

        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (32'(win) == NR - 1) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rambit_ctrl.sv
// Shares one single-port bit-masked RAM among NR requesters; clears the RAM after
// reset, then serves round-robin valid/ready accesses with 1-cycle read responses.
module rambit_ctrl
    import rambit_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 8,
    parameter int unsigned NR = 2
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [NR-1:0]    req_valid,
    output logic [NR-1:0]    req_ready,
    input  logic [NR-1:0]    req_write,
    input  logic [NR*AW-1:0] req_addr,
    input  logic [NR*DW-1:0] req_wmask,
    input  logic [NR*DW-1:0] req_wdata,
    output logic [NR-1:0]    rsp_valid,
    output logic [DW-1:0]    rsp_data,
    output logic             init_done,
    output logic             ram_ce,
    output logic [DW-1:0]    ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_din,
    input  logic [DW-1:0]    ram_dout
);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [NR-1:0] rsp_valid_q, rsp_valid_d;
    logic [NR-1:0] arb_req;
    logic [NR-1:0] grant;

    // Requests are invisible to the arbiter until the clear has finished.
    assign arb_req = (state_q == RUN) ? req_valid : '0;

    rambit_rrarb #(
        .NR (NR)
    ) u_arb (
        .clk     (clk),
        .nreset  (nreset),
        .req     (arb_req),
        .advance (|grant),
        .grant   (grant)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        ram_ce      = 1'b0;
        ram_we      = '0;
        ram_addr    = '0;
        ram_din     = '0;

        case (state_q)
            INIT: begin
                ram_ce   = 1'b1;
                ram_we   = '1;
                ram_addr = cnt_q;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NR; i++) begin
                    if (grant[i]) begin
                        ram_ce         = 1'b1;
                        ram_addr       = req_addr[i*AW +: AW];
                        ram_din        = req_wdata[i*DW +: DW];
                        ram_we         = req_write[i] ? req_wmask[i*DW +: DW] : '0;
                        rsp_valid_d[i] = ~req_write[i];
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = ram_dout;
    assign init_done = (state_q == RUN);

endmodule

// File: tb/tb_rambit_ctrl.sv
// Randomized bench for rambit_ctrl against a word-array reference model of the RAM
// contents, the round-robin rule and the one-cycle read response.
module tb_rambit_ctrl;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 8;
    localparam int unsigned NR    = 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             nreset = 1'b0;
    logic [NR-1:0]    req_valid, req_ready, req_write, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wmask, req_wdata;
    logic [DW-1:0]    rsp_data, ram_we, ram_din, ram_dout;
    logic [AW-1:0]    ram_addr;
    logic             init_done, ram_ce;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] ram [DEPTH];

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    int            ref_ptr;
    int            exp_rsp_req;
    logic [DW-1:0] exp_rsp_data;
    logic [DW-1:0] seen_data;

    always #5 clk = ~clk;

    rambit_ctrl #(
        .DW (DW),
        .AW (AW),
        .NR (NR)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wmask (req_wmask),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .init_done (init_done),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Single-port RAM with per-bit write enable and 1-cycle read latency.
    always @(posedge clk) begin
        if (ram_ce) begin
            ram_dout       <= ram[ram_addr];
            ram[ram_addr]  <= (ram[ram_addr] & ~ram_we) | (ram_din & ram_we);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        ref_ptr     = 0;
        exp_rsp_req = -1;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wmask = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] m, input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_write[i]          = wr;
        req_addr[i*AW +: AW]  = a;
        req_wmask[i*DW +: DW] = m;
        req_wdata[i*DW +: DW] = d;
    endtask

    // One RUN cycle: compare outputs at negedge, advance the model, return after posedge.
    task automatic cycle();
        int            w;
        logic [AW-1:0] a;
        logic [DW-1:0] m, d;
        @(negedge clk);
        w = -1;
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (ref_ptr + k) % NR;
            if (w < 0 && req_valid[j]) w = j;
        end
        check("init_done", 32'(init_done), 32'd1);
        check("rsp_valid", 32'(rsp_valid), (exp_rsp_req < 0) ? 32'd0 : 32'(1 << exp_rsp_req));
        if (exp_rsp_req >= 0) begin
            check("rsp_data", 32'(rsp_data), 32'(exp_rsp_data));
            seen_data = rsp_data;
        end
        check("req_ready", 32'(req_ready), (w < 0) ? 32'd0 : 32'(1 << w));
        check("ram_ce", 32'(ram_ce), (w >= 0) ? 32'd1 : 32'd0);
        exp_rsp_req = -1;
        if (w >= 0) begin
            a = req_addr[w*AW +: AW];
            m = req_wmask[w*DW +: DW];
            d = req_wdata[w*DW +: DW];
            check("ram_addr", 32'(ram_addr), 32'(a));
            check("ram_din", 32'(ram_din), 32'(d));
            check("ram_we", 32'(ram_we), req_write[w] ? 32'(m) : 32'd0);
            if (req_write[w]) begin
                ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
            end else begin
                exp_rsp_req  = w;
                exp_rsp_data = ref_mem[a];
            end
            ref_ptr = (w + 1) % NR;
        end else begin
            check("ram_we_idle", 32'(ram_we), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    // Call right after reset release at posedge+1; checks every clear cycle.
    task automatic run_init();
        model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            check("init_low", 32'(init_done), 32'd0);
            check("init_ce", 32'(ram_ce), 32'd1);
            check("init_we", 32'(ram_we), 32'hFFFF);
            check("init_din", 32'(ram_din), 32'd0);
            check("init_addr", 32'(ram_addr), 32'(k));
            check("init_ready", 32'(req_ready), 32'd0);
            check("init_rspv", 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        clear_reqs();
        model_reset();
        seen_data = '1;
        req_valid = '1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);

        // Request held through the clear; granted on the first RUN cycle.
        clear_reqs();
        set_req(0, 1'b0, 8'd5, '0, '0);
        nreset = 1'b1;
        run_init();
        cycle();
        clear_reqs();
        seen_data = '1;
        cycle();
        check("t1_rd5", 32'(seen_data), 32'h0000);

        // Partial-mask write then read back.
        set_req(0, 1'b1, 8'd3, 16'h00FF, 16'hABCD);
        cycle();
        clear_reqs();
        set_req(0, 1'b0, 8'd3, '0, '0);
        cycle();
        clear_reqs();
        seen_data = '1;
        cycle();
        check("t2_rd3", 32'(seen_data), 32'h00CD);

        // Both requesters reading continuously.
        set_req(0, 1'b0, 8'd10, '0, '0);
        set_req(1, 1'b0, 8'd3, '0, '0);
        repeat (4) cycle();
        clear_reqs();
        cycle();

        // Read-after-write across requesters.
        set_req(1, 1'b1, 8'd7, 16'hFFFF, 16'h1234);
        cycle();
        clear_reqs();
        set_req(0, 1'b0, 8'd7, '0, '0);
        cycle();
        clear_reqs();
        seen_data = '1;
        cycle();
        check("t4_rd7", 32'(seen_data), 32'h1234);

        // Randomized traffic on a small address window to force collisions.
        for (int n = 0; n < 400; n++) begin
            clear_reqs();
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    set_req(i, 1'($urandom), AW'($urandom_range(0, 15)),
                            DW'($urandom), DW'($urandom));
                end
            end
            cycle();
        end

        // Reset while a read response is pending.
        clear_reqs();
        set_req(0, 1'b0, 8'd7, '0, '0);
        cycle();
        clear_reqs();
        nreset = 1'b0;
        #1;
        check("t6_rspv", 32'(rsp_valid), 32'd0);
        check("t6_init", 32'(init_done), 32'd0);
        check("t6_addr", 32'(ram_addr), 32'd0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        model_reset();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            check("t6_part_addr", 32'(ram_addr), 32'(k));
        end
        @(posedge clk);
        #1;
        check("t6_cnt100", 32'(ram_addr), 32'd100);
        nreset = 1'b0;
        #1;
        check("t6_restart", 32'(ram_addr), 32'd0);
        check("t6_init2", 32'(init_done), 32'd0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        run_init();

        // Earlier writes must be gone after the second clear.
        set_req(0, 1'b0, 8'd3, '0, '0);
        set_req(1, 1'b0, 8'd7, '0, '0);
        cycle();
        cycle();
        clear_reqs();
        seen_data = '1;
        cycle();
        check("t6_rd7", 32'(seen_data), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
